// File: rtl/input_row_loader_if.sv
// Buffer read bus between the row loader (master) and a synchronous-read row buffer (slave).
// DATA_W/ADDR_W must match the loader instance that binds the master modport.
interface input_row_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/input_row_loader.sv
// Reads one N_ELEM-element row from a synchronous-read buffer into a registered row, then offers it downstream.
// Optional signed row maximum: define INPUT_ROW_LOADER_ROW_MAX_EN (otherwise o_row_max is tied to 0).
module input_row_loader #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_busy,
  input_row_loader_if.master     rd_bus,
  output logic [DATA_W-1:0]      o_row [N_ELEM],
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_W-1:0]      o_row_max,
  output logic [1:0]             o_dbg_state
);

  // Row handshake: o_valid rises once the whole row is captured and stays high, with o_row stable,
  // until a rising edge sees o_valid && i_ready; i_ready is ignored while o_valid is low.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_valid;
  logic              r_busy;
  logic              r_pv [RD_LAT];
  logic [ADDR_W-1:0] r_pa [RD_LAT];
  logic [DATA_W-1:0] r_row [N_ELEM];
  logic              w_inflight;
  logic              w_cap;
  logic [ADDR_W-1:0] w_cap_addr;
  logic [DATA_W-1:0] w_cap_data;

  assign w_cap      = r_pv[RD_LAT-1];
  assign w_cap_addr = r_pa[RD_LAT-1];
  assign w_cap_data = rd_bus.rd_data;

  // Requests still travelling through the pipeline, excluding the one landing this cycle.
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      w_inflight = w_inflight | r_pv[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_READ;
      S_READ:  if (r_rd_addr == LAST_ADDR) w_state_next = S_DRAIN;
      S_DRAIN: if (!w_inflight) w_state_next = S_DONE;
      S_DONE:  if (i_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Every output is registered from the next state so it lines up with the state it describes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
      for (int i = 0; i < N_ELEM; i++) begin
        r_row[i] <= '0;
      end
    end else begin
      r_rd_en <= (w_state_next == S_READ);
      r_valid <= (w_state_next == S_DONE);
      r_busy  <= (w_state_next != S_IDLE);
      if (r_state == S_IDLE && w_state_next == S_READ) begin
        r_rd_addr <= '0;
      end else if (r_state == S_READ && w_state_next == S_READ) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
      r_pv[0] <= r_rd_en;
      r_pa[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
      if (w_cap) begin
        r_row[w_cap_addr] <= w_cap_data;
      end
    end
  end

`ifdef INPUT_ROW_LOADER_ROW_MAX_EN
  logic [DATA_W-1:0] r_row_max;

  // Address 0 reseeds the running max for each row; ties keep the held value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row_max <= '0;
    end else if (w_cap) begin
      if (w_cap_addr == '0 || $signed(w_cap_data) > $signed(r_row_max)) begin
        r_row_max <= w_cap_data;
      end
    end
  end

  assign o_row_max = r_row_max;
`else
  assign o_row_max = '0;
`endif

  assign rd_bus.rd_en   = r_rd_en;
  assign rd_bus.rd_addr = r_rd_addr;
  assign o_row          = r_row;
  assign o_valid        = r_valid;
  assign o_busy         = r_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_input_row_loader.sv
// Bench for input_row_loader: one instance with RD_LAT=1 and one with RD_LAT=3, each fed by a buffer model.
// Table-driven row loads plus hand-written reset-abort and handshake-hold sequences.
module tb_input_row_loader;
  localparam int DW = 16;
  localparam int N  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic ready = 1'b0;

  always #5 clk = ~clk;

  input_row_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  input_row_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

  logic          busy1, valid1, busy3, valid3;
  logic [DW-1:0] row1 [N];
  logic [DW-1:0] row3 [N];
  logic [DW-1:0] max1, max3;
  logic [1:0]    st1, st3;

  input_row_loader #(.DATA_W(DW), .N_ELEM(N), .ADDR_W(AW), .RD_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .rd_bus(bus1),
    .o_row(row1), .o_valid(valid1), .i_ready(ready), .o_row_max(max1), .o_dbg_state(st1)
  );

  input_row_loader #(.DATA_W(DW), .N_ELEM(N), .ADDR_W(AW), .RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .o_busy(busy3), .rd_bus(bus3),
    .o_row(row3), .o_valid(valid3), .i_ready(ready), .o_row_max(max3), .o_dbg_state(st3)
  );

  // Buffer models: data for a request appears RD_LAT cycles later; idle slots carry junk.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] pipe1 [1];
  logic [DW-1:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1[0] <= bus1.rd_en ? mem[bus1.rd_addr] : 16'hDEAD;
  end
  always @(posedge clk) begin
    pipe3[0] <= bus3.rd_en ? mem[bus3.rd_addr] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.rd_data = pipe1[0];
  assign bus3.rd_data = pipe3[2];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           pattern;
    int           sel;
    int           hold;
    bit           poke;
    logic [DW-1:0] max_on;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else start1 = v;
  endtask

  function automatic logic get_en(input int sel);
    return (sel != 0) ? bus3.rd_en : bus1.rd_en;
  endfunction
  function automatic logic [AW-1:0] get_addr(input int sel);
    return (sel != 0) ? bus3.rd_addr : bus1.rd_addr;
  endfunction
  function automatic logic get_valid(input int sel);
    return (sel != 0) ? valid3 : valid1;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy3 : busy1;
  endfunction
  function automatic logic [DW-1:0] get_row(input int sel, input int a);
    return (sel != 0) ? row3[a] : row1[a];
  endfunction
  function automatic logic [DW-1:0] get_max(input int sel);
    return (sel != 0) ? max3 : max1;
  endfunction

  task automatic fill(input int pattern);
    for (int a = 0; a < N; a++) begin
      case (pattern)
        0: mem[a] = 16'h0100 + DW'(a);
        1: mem[a] = 16'h0000;
        2: mem[a] = 16'hFFFE;
        default: mem[a] = 16'hFF00 - DW'(a);
      endcase
    end
    if (pattern == 1) begin
      mem[0]  = 16'h8000;
      mem[1]  = 16'hFFFB;
      mem[2]  = 16'h0007;
      mem[31] = 16'h7FFF;
    end
  endtask

  task automatic do_load(input int sel, input int hold, input bit poke, input logic [DW-1:0] max_on);
    int seq_err, rise_c, hold_err, row_err, extra, lat;
    logic [DW-1:0] snap [N];
    logic [DW-1:0] exp_max;
    seq_err = 0; rise_c = -1; hold_err = 0; row_err = 0; extra = 0;
    lat = (sel != 0) ? 3 : 1;
`ifdef INPUT_ROW_LOADER_ROW_MAX_EN
    exp_max = max_on;
`else
    exp_max = '0;
`endif
    ready = (hold == 0);
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    for (int c = 1; c <= N + 12; c++) begin
      if (get_valid(sel)) begin
        rise_c = c;
        break;
      end
      if (get_en(sel) !== (c <= N)) seq_err++;
      else if (c <= N && get_addr(sel) !== AW'(c - 1)) seq_err++;
      set_start(sel, poke && c == 10);
      step();
    end
    set_start(sel, 1'b0);
    check("rd_seq", seq_err, 0);
    check("valid_rise_cycle", rise_c, N + lat + 1);
    check("busy_in_done", {31'd0, get_busy(sel)}, 1);
    for (int a = 0; a < N; a++) snap[a] = get_row(sel, a);
    for (int h = 0; h < hold; h++) begin
      set_start(sel, poke && h == 2);
      step();
      if (get_valid(sel) !== 1'b1) hold_err++;
      for (int a = 0; a < N; a++) if (get_row(sel, a) !== snap[a]) hold_err++;
    end
    if (hold > 0) check("hold_stable", hold_err, 0);
    set_start(sel, poke);
    ready = 1'b1;
    step();
    set_start(sel, 1'b0);
    check("valid_drop", {31'd0, get_valid(sel)}, 0);
    check("busy_idle", {31'd0, get_busy(sel)}, 0);
    for (int k = 0; k < 40; k++) begin
      if (get_en(sel) !== 1'b0 || get_valid(sel) !== 1'b0) extra++;
      step();
    end
    check("no_extra_reads", extra, 0);
    for (int a = 0; a < N; a++) if (get_row(sel, a) !== mem[a]) row_err++;
    check("row_contents", row_err, 0);
    check("row_max", {16'd0, get_max(sel)}, {16'd0, exp_max});
  endtask

  task automatic check_reset_outputs(input string tag);
    int zero_err;
    zero_err = 0;
    for (int a = 0; a < N; a++) begin
      if (row1[a] !== '0) zero_err++;
      if (row3[a] !== '0) zero_err++;
    end
    check({tag, "_row_zero"}, zero_err, 0);
    check({tag, "_ctrl1"}, {26'd0, bus1.rd_en, bus1.rd_addr}, 0);
    check({tag, "_ctrl3"}, {26'd0, bus3.rd_en, bus3.rd_addr}, 0);
    check({tag, "_valid_busy"}, {28'd0, valid1, busy1, valid3, busy3}, 0);
    check({tag, "_max"}, {max1, max3}, 0);
    check({tag, "_state"}, {28'd0, st1, st3}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{pattern: 0, sel: 0, hold: 0,  poke: 1'b0, max_on: 16'h011F};
    vecs[1] = '{pattern: 0, sel: 0, hold: 10, poke: 1'b1, max_on: 16'h011F};
    vecs[2] = '{pattern: 0, sel: 1, hold: 0,  poke: 1'b0, max_on: 16'h011F};
    vecs[3] = '{pattern: 1, sel: 0, hold: 0,  poke: 1'b0, max_on: 16'h7FFF};
    vecs[4] = '{pattern: 2, sel: 0, hold: 0,  poke: 1'b0, max_on: 16'hFFFE};
    vecs[5] = '{pattern: 1, sel: 1, hold: 3,  poke: 1'b1, max_on: 16'h7FFF};
    vecs[6] = '{pattern: 3, sel: 1, hold: 0,  poke: 1'b0, max_on: 16'hFF00};

    fill(0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      fill(vecs[i].pattern);
      do_load(vecs[i].sel, vecs[i].hold, vecs[i].poke, vecs[i].max_on);
    end

    // Abort a load in its 15th read cycle; nothing may surface afterwards.
    fill(0);
    ready = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (14) step();
    check("abort_reading", {31'd0, bus1.rd_en}, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (valid1 !== 1'b0 || bus1.rd_en !== 1'b0) seen++;
      step();
    end
    check("abort_no_valid", seen, 0);
    do_load(0, 0, 1'b0, 16'h011F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_row_loader.md
Name: input_row_loader

Overview:
- Upstream stage of the softmax row path. On a start pulse it reads one N_ELEM-element row from a synchronous-read buffer (addresses 0..N_ELEM-1), assembles it into a registered row array, then presents the row to the softmax core with a valid/ready handshake.
- Mirrors the downstream row flattener: memory to row here, row to memory there.

Parameters:
- DATA_W, 16, element width in bits (two's complement where signed compare applies)
- N_ELEM, 32, elements per row
- ADDR_W, 5, buffer address width; must satisfy 2**ADDR_W >= N_ELEM
- RD_LAT, 1, buffer read latency in cycles (>=1); rd_data for a request is valid RD_LAT cycles after the cycle rd_en is high

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_start  input  1  start a row load; sampled only in IDLE
- o_busy  output  1  high in READ, DRAIN and DONE
- rd_en  output  1  buffer read request
- rd_addr  output  ADDR_W  buffer read address
- rd_data  input  DATA_W  buffer read data
- o_row  output  DATA_W x N_ELEM (unpacked array)  assembled row
- o_valid  output  1  row valid; held until accepted
- i_ready  input  1  consumer accepts the row when high with o_valid
- o_row_max  output  DATA_W  signed maximum of row (see Optional Feature)

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; rd_en=0, rd_addr=0, o_valid=0, o_busy=0, o_row_max=0, all o_row entries=0.
  - The read-tracking pipeline is cleared, so in-flight returns are discarded.
  - Reset mid-operation aborts the load. No partial o_valid follows.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on i_start=1, go to READ with issue counter=0. i_start has no effect in any other state.
  - READ: rd_en=1 and rd_addr=counter, incrementing one address per cycle for exactly N_ELEM consecutive cycles (addresses 0..N_ELEM-1, no gaps). After the N_ELEM-1 request, rd_en=0 and the FSM goes to DRAIN.
  - DRAIN: wait until every outstanding return has been captured, then set o_valid=1 and go to DONE.
  - DONE: o_valid=1 and o_row is stable. When o_valid and i_ready are both high at a rising edge, o_valid=0 and the FSM returns to IDLE. i_start in that same cycle is ignored; a new load needs i_start in a later IDLE cycle.
- Capture:
  - A shift pipeline of depth RD_LAT carries (valid, address) for each request.
  - When the tail is valid, o_row[address] <= rd_data.
  - o_row entries not yet written keep their previous values. No partial-row guarantees apply before o_valid.
- Latency:
  - Rising edge E0 samples i_start.
  - rd_en is high for cycles 1..N_ELEM after E0.
  - o_valid rises immediately after edge E0+N_ELEM+RD_LAT. Defaults: 33 edges.
- Back-to-back throughput: one row per N_ELEM+RD_LAT+2 cycles minimum, assuming i_ready is high in DONE.
- i_ready while o_valid=0 is ignored.
- rd_addr holds its last value when rd_en=0.

Optional Feature:
- Macro: INPUT_ROW_LOADER_ROW_MAX_EN.
- Defined:
  - A running signed max register is initialised from the first captured element (address 0) of each row and updated with each subsequent capture.
  - o_row_max is valid with o_valid and equals the signed maximum of all N_ELEM elements.
  - Ties keep the existing value.
- Not defined: no compare logic is built and o_row_max is tied to 0. All other behaviour is identical.

Test Plan:
- Buffer holds data[a]=16'h0100+a, RD_LAT=1. Pulse i_start at edge 0, i_ready=1. Required response:
  - rd_en high for cycles 1..32 with rd_addr=0..31.
  - o_valid rises after edge 33 for exactly one cycle.
  - o_row[a]=16'h0100+a for every a.
- Same data, i_ready=0 for 10 cycles after o_valid rises:
  - o_valid and o_row held unchanged for those cycles.
  - Transfer completes on the first i_ready=1 edge.
  - i_start pulsed during DONE and during READ produces no extra reads.
- Assert i_rst at cycle 15 of READ for 1 cycle:
  - All outputs return to reset values at once and no o_valid follows.
  - A fresh i_start then loads the full row correctly.
- Rebuild with RD_LAT=3:
  - o_valid rises after edge 35.
  - o_row matches buffer contents (no off-by-latency shift).
- With INPUT_ROW_LOADER_ROW_MAX_EN defined, row = {16'sh8000, -5, 7, ..., 16'sh7FFF at address 31, rest 0}: o_row_max=16'h7FFF.
- With INPUT_ROW_LOADER_ROW_MAX_EN defined, row of all 16'hFFFE (-2): o_row_max=16'hFFFE.
- Without INPUT_ROW_LOADER_ROW_MAX_EN: o_row_max=0 for both rows above.
